// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: raster timing generator and DAC output stage.
//
// Runs horizontal/vertical counters on the pixel clock, issues pixel coordinates
// and a request strobe to the pattern generator one clock ahead of the active
// pixel, then registers the returned RGB together with HS/VS/BLANK_N.
//
// Ports:
//   iVGA_CLK, iRST_N        pixel clock, asynchronous active-low reset
//   iRed/iGreen/iBlue       10-bit RGB from pattern generator (1 clock after oRequest)
//   oVGA_X/oVGA_Y/oRequest  requested pixel coordinate and its valid strobe
//   oVGA_R/G/B              DAC colour, forced to 0 while blanked
//   oVGA_HS/oVGA_VS         active-low syncs
//   oVGA_BLANK_N            high during active video
//   oFrameStart             one-clock pulse on the first output clock of a frame
module vga_timing_ctrl #(
    parameter int unsigned H_FRONT = 16,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BACK  = 48,
    parameter int unsigned H_ACT   = 640,
    parameter int unsigned V_FRONT = 10,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BACK  = 33,
    parameter int unsigned V_ACT   = 480
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_N,
    input  logic [9:0] iRed,
    input  logic [9:0] iGreen,
    input  logic [9:0] iBlue,
    output logic [9:0] oVGA_X,
    output logic [9:0] oVGA_Y,
    output logic       oRequest,
    output logic [9:0] oVGA_R,
    output logic [9:0] oVGA_G,
    output logic [9:0] oVGA_B,
    output logic       oVGA_HS,
    output logic       oVGA_VS,
    output logic       oVGA_BLANK_N,
    output logic       oFrameStart
);

    localparam int unsigned H_BLANK = H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned H_TOTAL = H_BLANK + H_ACT;
    localparam int unsigned V_BLANK = V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned V_TOTAL = V_BLANK + V_ACT;

    localparam logic [10:0] HLast      = 11'(H_TOTAL - 1);
    localparam logic [10:0] HSyncStart = 11'(H_FRONT);
    localparam logic [10:0] HSyncEnd   = 11'(H_FRONT + H_SYNC);
    localparam logic [10:0] HActStart  = 11'(H_BLANK);
    // Request runs one clock ahead of the active window to cover the
    // pattern generator's registered latency.
    localparam logic [10:0] HReqStart  = 11'(H_BLANK - 1);
    localparam logic [10:0] HReqEnd    = 11'(H_TOTAL - 2);
    localparam logic [10:0] VLast      = 11'(V_TOTAL - 1);
    localparam logic [10:0] VSyncStart = 11'(V_FRONT);
    localparam logic [10:0] VSyncEnd   = 11'(V_FRONT + V_SYNC);
    localparam logic [10:0] VActStart  = 11'(V_BLANK);

    logic [10:0] hc_q, hc_d;
    logic [10:0] vc_q, vc_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        blank_n_q, act;
    logic        frame_q, frame_d;
    logic [9:0]  r_q, r_d;
    logic [9:0]  g_q, g_d;
    logic [9:0]  b_q, b_d;
    logic        req;

    // Raster counters: vc advances only on the last clock of a line.
    always_comb begin
        hc_d = hc_q + 11'd1;
        vc_d = vc_q;
        if (hc_q == HLast) begin
            hc_d = '0;
            vc_d = (vc_q == VLast) ? '0 : vc_q + 11'd1;
        end
    end

    // Request window and coordinates decoded from the registered counters.
    always_comb begin
        req      = (vc_q >= VActStart) && (hc_q >= HReqStart) && (hc_q <= HReqEnd);
        oRequest = req;
        oVGA_X   = req ? 10'(hc_q - HReqStart) : '0;
        oVGA_Y   = req ? 10'(vc_q - VActStart) : '0;
    end

    // Next values for the DAC-side output register.
    always_comb begin
        act     = (hc_q >= HActStart) && (vc_q >= VActStart);
        hs_d    = !((hc_q >= HSyncStart) && (hc_q < HSyncEnd));
        vs_d    = !((vc_q >= VSyncStart) && (vc_q < VSyncEnd));
        frame_d = (hc_q == '0) && (vc_q == '0);
        r_d     = act ? iRed   : '0;
        g_d     = act ? iGreen : '0;
        b_d     = act ? iBlue  : '0;
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            hc_q      <= '0;
            vc_q      <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            frame_q   <= 1'b0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
        end else begin
            hc_q      <= hc_d;
            vc_q      <= vc_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= act;
            frame_q   <= frame_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
        end
    end

    assign oVGA_HS      = hs_q;
    assign oVGA_VS      = vs_q;
    assign oVGA_BLANK_N = blank_n_q;
    assign oFrameStart  = frame_q;
    assign oVGA_R       = r_q;
    assign oVGA_G       = g_q;
    assign oVGA_B       = b_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl using a shrunken raster so whole frames fit in a short run.
// A registered pattern generator returns R=X, G=X+1, B=~X (or constant white).
module tb_vga_timing_ctrl;

    localparam int HF  = 4;
    localparam int HSW = 6;
    localparam int HBP = 5;
    localparam int HA  = 16;
    localparam int VF  = 2;
    localparam int VSW = 2;
    localparam int VBP = 3;
    localparam int VA  = 6;
    localparam int HB  = HF + HSW + HBP;  // 15
    localparam int HT  = HB + HA;         // 31
    localparam int VB  = VF + VSW + VBP;  // 7
    localparam int VT  = VB + VA;         // 13
    localparam int FT  = HT * VT;         // 403 clocks per frame

    typedef struct packed {
        logic       req;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       bn;
        logic       fs;
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
    } obs_t;

    logic       clk;
    logic       rst_n;
    logic [9:0] red, green, blue;
    logic [9:0] vga_x, vga_y, vga_r, vga_g, vga_b;
    logic       request, vga_hs, vga_vs, vga_blank_n, frame_start;
    bit         white;
    int         cyc;
    int         errors;
    int         checks;
    obs_t       obs;
    obs_t       expv;

    vga_timing_ctrl #(
        .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HBP), .H_ACT(HA),
        .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VBP), .V_ACT(VA)
    ) dut (
        .iVGA_CLK    (clk),
        .iRST_N      (rst_n),
        .iRed        (red),
        .iGreen      (green),
        .iBlue       (blue),
        .oVGA_X      (vga_x),
        .oVGA_Y      (vga_y),
        .oRequest    (request),
        .oVGA_R      (vga_r),
        .oVGA_G      (vga_g),
        .oVGA_B      (vga_b),
        .oVGA_HS     (vga_hs),
        .oVGA_VS     (vga_vs),
        .oVGA_BLANK_N(vga_blank_n),
        .oFrameStart (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pattern generator with one clock of registered latency.
    always @(posedge clk) begin
        if (white) begin
            red   <= 10'h3FF;
            green <= 10'h3FF;
            blue  <= 10'h3FF;
        end else begin
            red   <= vga_x;
            green <= vga_x + 10'd1;
            blue  <= ~vga_x;
        end
    end

    assign obs = {request, vga_x, vga_y, vga_hs, vga_vs, vga_blank_n, frame_start,
                  vga_r, vga_g, vga_b};

    // Expected view at the negedge after the t-th clock since reset release:
    // counters hold position t, the output register shows position t-1.
    function automatic obs_t model(int t, bit w);
        obs_t m;
        int h, v, ph, pv;
        logic [9:0] c;
        h  = t % HT;
        v  = (t / HT) % VT;
        ph = (t - 1) % HT;
        pv = ((t - 1) / HT) % VT;
        m.req = (v >= VB) && (h >= HB - 1) && (h <= HT - 2);
        m.x   = m.req ? 10'(h - (HB - 1)) : 10'd0;
        m.y   = m.req ? 10'(v - VB) : 10'd0;
        m.hs  = !((ph >= HF) && (ph < HF + HSW));
        m.vs  = !((pv >= VF) && (pv < VF + VSW));
        m.bn  = (ph >= HB) && (pv >= VB);
        m.fs  = (ph == 0) && (pv == 0);
        c     = 10'(ph - HB);
        if (!m.bn) begin
            m.r = '0; m.g = '0; m.b = '0;
        end else if (w) begin
            m.r = 10'h3FF; m.g = 10'h3FF; m.b = 10'h3FF;
        end else begin
            m.r = c; m.g = c + 10'd1; m.b = ~c;
        end
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (vga_hs !== 1'b1) begin errors++; $display("FAIL reset_hs: got %b want 1", vga_hs); end
        checks++; if (vga_vs !== 1'b1) begin errors++; $display("FAIL reset_vs: got %b want 1", vga_vs); end
        checks++; if (vga_blank_n !== 1'b0) begin errors++; $display("FAIL reset_blank_n: got %b want 0", vga_blank_n); end
        checks++; if ({vga_r, vga_g, vga_b} !== 30'd0) begin errors++; $display("FAIL reset_rgb: got %h want 0", {vga_r, vga_g, vga_b}); end
        checks++; if (request !== 1'b0) begin errors++; $display("FAIL reset_request: got %b want 0", request); end
        checks++; if ({vga_x, vga_y} !== 20'd0) begin errors++; $display("FAIL reset_xy: got %h want 0", {vga_x, vga_y}); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b want 0", frame_start); end
        rst_n = 1'b1;
        cyc   = 0;
        step();
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL first_frame_start: got %b want 1", frame_start); end
    endtask

    task automatic test_sync();
        int hs_low = 0, vs_low = 0, first_hs = 0, fall0 = 0, fall1 = 0;
        logic prev_hs = 1'b1;
        while (cyc < FT) begin
            step();
            expv = model(cyc, white);
            checks++; if (obs !== expv) begin errors++; $display("FAIL raster_sync t=%0d: got %h want %h", cyc, obs, expv); end
            if (cyc <= HT && !vga_hs) begin
                hs_low++;
                if (first_hs == 0) first_hs = cyc;
            end
            if (!vga_vs) vs_low++;
            if (prev_hs && !vga_hs) begin
                if (fall0 == 0) fall0 = cyc; else if (fall1 == 0) fall1 = cyc;
            end
            prev_hs = vga_hs;
        end
        checks++; if (hs_low != HSW) begin errors++; $display("FAIL hs_width: got %0d want %0d", hs_low, HSW); end
        checks++; if (first_hs != HF + 1) begin errors++; $display("FAIL hs_start: got %0d want %0d", first_hs, HF + 1); end
        checks++; if (fall1 - fall0 != HT) begin errors++; $display("FAIL line_period: got %0d want %0d", fall1 - fall0, HT); end
        checks++; if (vs_low != VSW * HT) begin errors++; $display("FAIL vs_width: got %0d want %0d", vs_low, VSW * HT); end
    endtask

    task automatic test_request_window();
        int cnt = 0, first_h = -1, last_h = -1, early = 0, seq_bad = 0, max_y = 0;
        logic [9:0] first_x = '1, first_y = '1, last_x = '0, prev_x = '0;
        logic prev_req = 1'b0;
        int h, v;
        repeat (FT) begin
            step();
            expv = model(cyc, white);
            checks++; if (obs !== expv) begin errors++; $display("FAIL raster_req t=%0d: got %h want %h", cyc, obs, expv); end
            h = cyc % HT;
            v = (cyc / HT) % VT;
            if (request) begin
                if (v < VB) early++;
                if (int'(vga_y) > max_y) max_y = int'(vga_y);
                if (prev_req && vga_x != prev_x + 10'd1) seq_bad++;
                if (v == VB) begin
                    cnt++;
                    if (first_h < 0) begin first_h = h; first_x = vga_x; first_y = vga_y; end
                    last_h = h;
                    last_x = vga_x;
                end
            end
            prev_req = request;
            prev_x   = vga_x;
        end
        checks++; if (cnt != HA) begin errors++; $display("FAIL req_count: got %0d want %0d", cnt, HA); end
        checks++; if (first_h != HB - 1) begin errors++; $display("FAIL req_first_h: got %0d want %0d", first_h, HB - 1); end
        checks++; if ({first_x, first_y} !== 20'd0) begin errors++; $display("FAIL req_first_xy: got %h want 0", {first_x, first_y}); end
        checks++; if (last_h != HT - 2) begin errors++; $display("FAIL req_last_h: got %0d want %0d", last_h, HT - 2); end
        checks++; if (last_x !== 10'(HA - 1)) begin errors++; $display("FAIL req_last_x: got %0d want %0d", last_x, HA - 1); end
        checks++; if (early != 0) begin errors++; $display("FAIL req_in_vblank: got %0d want 0", early); end
        checks++; if (seq_bad != 0) begin errors++; $display("FAIL req_x_step: got %0d want 0", seq_bad); end
        checks++; if (max_y != VA - 1) begin errors++; $display("FAIL req_max_y: got %0d want %0d", max_y, VA - 1); end
    endtask

    task automatic test_alignment();
        int bad = 0, bn_cnt = 0, hs_fall = -1, gap = -1;
        logic [9:0] col = '0;
        logic prev_bn = 1'b0, prev_hs = 1'b1;
        repeat (FT) begin
            step();
            expv = model(cyc, white);
            checks++; if (obs !== expv) begin errors++; $display("FAIL raster_align t=%0d: got %h want %h", cyc, obs, expv); end
            if (prev_hs && !vga_hs) hs_fall = cyc;
            if (vga_blank_n) begin
                if (!prev_bn) begin
                    col = '0;
                    if (gap < 0 && hs_fall >= 0) gap = cyc - hs_fall;
                end
                if (vga_r !== col) bad++;
                col = col + 10'd1;
                bn_cnt++;
            end
            prev_bn = vga_blank_n;
            prev_hs = vga_hs;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL align_column: got %0d bad want 0", bad); end
        checks++; if (gap != HSW + HBP) begin errors++; $display("FAIL hs_to_active: got %0d want %0d", gap, HSW + HBP); end
        checks++; if (bn_cnt != HA * VA) begin errors++; $display("FAIL active_count: got %0d want %0d", bn_cnt, HA * VA); end
    endtask

    task automatic test_midframe_reset();
        bit found = 0;
        obs_t rst_obs;
        rst_obs = '0;
        rst_obs.hs = 1'b1;
        rst_obs.vs = 1'b1;
        for (int i = 0; i < FT && !found; i++) begin
            step();
            expv = model(cyc, white);
            checks++; if (obs !== expv) begin errors++; $display("FAIL raster_pre t=%0d: got %h want %h", cyc, obs, expv); end
            if (cyc % HT == HB + 5 && (cyc / HT) % VT == VB + 1) found = 1;
        end
        checks++; if (!found || vga_blank_n !== 1'b1 || request !== 1'b1) begin
            errors++; $display("FAIL midframe_point: found=%0d bn=%b req=%b want 1/1/1", found, vga_blank_n, request);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (obs !== rst_obs) begin errors++; $display("FAIL async_reset: got %h want %h", obs, rst_obs); end
        white = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (obs !== rst_obs) begin errors++; $display("FAIL reset_hold: got %h want %h", obs, rst_obs); end
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_white_frame();
        int wcnt = 0, fs_cnt = 0, fs_first = -1, fs_last = -1;
        repeat (FT + 1) begin
            step();
            expv = model(cyc, white);
            checks++; if (obs !== expv) begin errors++; $display("FAIL raster_white t=%0d: got %h want %h", cyc, obs, expv); end
            if (vga_blank_n && {vga_r, vga_g, vga_b} == {3{10'h3FF}}) wcnt++;
            if (frame_start) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = cyc;
                fs_last = cyc;
            end
        end
        checks++; if (wcnt != HA * VA) begin errors++; $display("FAIL white_count: got %0d want %0d", wcnt, HA * VA); end
        checks++; if (fs_first != 1) begin errors++; $display("FAIL restart_fs: got %0d want 1", fs_first); end
        checks++; if (fs_cnt != 2 || fs_last - fs_first != FT) begin
            errors++; $display("FAIL frame_period: got cnt=%0d gap=%0d want cnt=2 gap=%0d", fs_cnt, fs_last - fs_first, FT);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        white  = 1'b0;
        rst_n  = 1'b0;
        test_reset();
        test_sync();
        test_request_window();
        test_alignment();
        test_midframe_reset();
        test_white_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Raster timing generator and output stage for the monitor path.
- Runs horizontal and vertical counters on the pixel clock and issues pixel coordinates plus a request strobe to the upstream pattern generator.
- The pattern generator returns 10-bit RGB one clock later. This block aligns that data with registered HS/VS/BLANK_N and drives the VGA DAC pins.
- Default timing is 640x480@60 (25 MHz pixel clock).

Parameters:
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, HS pulse width (clocks)
H_BACK, 48, horizontal back porch (clocks)
H_ACT, 640, active pixels per line
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, VS pulse width (lines)
V_BACK, 33, vertical back porch (lines)
V_ACT, 480, active lines per frame

Ports:
iVGA_CLK  input  1  pixel clock
iRST_N  input  1  reset, asynchronous, active-low
iRed  input  10  red from pattern generator, valid the cycle after oRequest
iGreen  input  10  green, same timing as iRed
iBlue  input  10  blue, same timing as iRed
oVGA_X  output  10  requested pixel column (to pattern generator iVGA_X)
oVGA_Y  output  10  requested pixel row (to pattern generator iVGA_Y)
oRequest  output  1  coordinate valid strobe
oVGA_R  output  10  DAC red
oVGA_G  output  10  DAC green
oVGA_B  output  10  DAC blue
oVGA_HS  output  1  horizontal sync, active-low
oVGA_VS  output  1  vertical sync, active-low
oVGA_BLANK_N  output  1  high during active video
oFrameStart  output  1  one-clock pulse at the first output clock of each frame

Behaviour:
- Derived values: H_BLANK=H_FRONT+H_SYNC+H_BACK (160), H_TOTAL=H_BLANK+H_ACT (800), V_BLANK=V_FRONT+V_SYNC+V_BACK (45), V_TOTAL=V_BLANK+V_ACT (525). Counters are 11 bits wide.
- Line order: front porch, sync, back porch, active. A frame uses the same order in lines.
- hc counts 0..H_TOTAL-1 and wraps to 0.
- vc increments only on the clock where hc==H_TOTAL-1, and wraps from V_TOTAL-1 to 0 on that same clock.
- Active decode: act(hc,vc) = (hc>=H_BLANK) && (vc>=V_BLANK).
- Request window (combinational decode of the registered counters):
  - oRequest=1 when vc>=V_BLANK and H_BLANK-1 <= hc <= H_TOTAL-2.
  - oVGA_X = hc-(H_BLANK-1) and oVGA_Y = vc-V_BLANK while oRequest=1; otherwise both are 0.
  - The request therefore leads the active pixel by exactly one clock, which matches the pattern generator's 1-clock registered latency.
- Output register (all DAC-side outputs update on the clock edge ending the cycle with counter value hc,vc):
  - oVGA_HS = !(H_FRONT <= hc < H_FRONT+H_SYNC).
  - oVGA_VS = !(V_FRONT <= vc < V_FRONT+V_SYNC).
  - oVGA_BLANK_N = act(hc,vc).
  - oVGA_R/G/B = act ? iRed/iGreen/iBlue : 0.
  - oFrameStart = (hc==0 && vc==0).
- End-to-end timing:
  - Pixel (x,y) is requested at hc=H_BLANK-1+x.
  - Its RGB enters the block at hc=H_BLANK+x.
  - It appears on the pins one clock later, aligned with its HS/VS/BLANK_N.
- Blanked cycles force RGB to 0 regardless of the iRed/iGreen/iBlue values.
- Reset (asynchronous, any time including mid-frame):
  - hc=vc=0, oVGA_HS=1, oVGA_VS=1, oVGA_BLANK_N=0, RGB=0, oFrameStart=0.
  - oRequest, oVGA_X and oVGA_Y decode to 0.
  - After release the frame restarts from hc=vc=0; the first oFrameStart pulse occurs one clock after release.
- No back-pressure: the pattern generator must always return data in one clock.

Test Plan:
- Reset: hold iRST_N=0 for 5 clocks -> HS=VS=1, BLANK_N=0, RGB=0, oRequest=0, X=Y=0. Release -> oFrameStart pulses once on the first clock, then again exactly 420000 clocks later.
- HS timing: count clocks after release -> HS low for exactly 96 clocks, asserted from the edge ending hc=16. Line period is 800 clocks. VS is low for 1600 clocks (2 lines).
- Request window: on line vc=45 -> oRequest rises at hc=159 with X=0, Y=0. On that line the last request is at hc=798 with X=639, oRequest is high for 640 clocks, and X increments by 1 each clock. On line vc=524 -> Y=479. On lines vc<45 -> no request.
- Alignment: connect a pattern generator that returns RGB = registered {X,X,X} -> every clock with BLANK_N=1 shows oVGA_R equal to the pixel column, 0..639 in order. The first active output follows the falling edge of HS by 144 clocks (back-porch end).
- Constant-white source (1023 on all channels) -> exactly 640x480=307200 clocks per frame have BLANK_N=1 with RGB=1023. All other clocks show RGB=0.
- Mid-frame reset at vc=200, hc=400 -> outputs return to reset values immediately (asynchronously). After release, HS/VS/request timing matches a fresh start clock-for-clock.
